inport_fifo: RTL and testbench
==============================

Name: inport_fifo

Overview:
- Input-port buffer between an external device and the CPU datapath.
- Device side: 32-bit words pushed through a valid/ready handshake.
- CPU side: the control unit pulses a read strobe during an `in` instruction; the head word drives the datapath's input-port data lines (device_data).
- Decouples device timing from instruction timing, so no words are lost while the CPU is busy.

Parameters:
- DEPTH, 8, number of 32-bit entries; power of 2, minimum 2.
- IRQ_LEVEL, 4, occupancy at or above which irq asserts (optional feature only); range 1..DEPTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- dev_data  in  32  word offered by the device.
- dev_valid  in  1  device has a word on dev_data.
- dev_ready  out  1  FIFO can accept a word this cycle.
- InPort_read  in  1  CPU consumes the head word; one pop per cycle held high.
- InPort_data_out  out  32  head word, to the datapath input-port data.
- empty  out  1  no entries held.
- full  out  1  DEPTH entries held.
- count  out  $clog2(DEPTH+1)  current occupancy.
- underflow  out  1  sticky: a read was attempted while empty.
- irq  out  1  optional feature only; tied 0 when the feature is compiled out.

Behaviour:
- Storage: DEPTH x 32 array; wr_ptr and rd_ptr are $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count is held in its own register.
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, underflow=0.
  - Outputs: empty=1, full=0, dev_ready=1, InPort_data_out=0, irq=0.
  - Array contents are not cleared.
  - Reset mid-transfer discards all held words; no push or pop completes on the edge where reset is asserted.
- Derived outputs: dev_ready = !full, combinational from registered count only; never depends on InPort_read, so there is no device-to-CPU combinational path.
- Push: dev_valid && dev_ready at a rising edge writes mem[wr_ptr] and increments wr_ptr. A word offered while full is not taken; the device must hold it until dev_ready=1.
- Pop: InPort_read && !empty at a rising edge increments rd_ptr.
- InPort_data_out (show-ahead):
  - Equals mem[rd_ptr] whenever !empty; the word is valid in the same cycle the strobe is issued.
  - Forced to 0 when empty.
  - Latency: a word pushed at edge N is visible on InPort_data_out after edge N when the FIFO was empty.
- Simultaneous push and pop, 0<count<DEPTH: both occur and count is unchanged.
- Push and read when empty: the push occurs; the read is an underflow, so count becomes 1 and underflow is set.
- Read while full with dev_valid=1: the pop occurs; no push that cycle, because dev_ready=0; dev_ready rises the following cycle.
- underflow: set by InPort_read && empty; cleared only by reset.
- count update: count + push - pop, never exceeding DEPTH and never below 0.

Optional Feature:
- Macro: INPORT_FIFO_IRQ_EN.
- Defined:
  - Registered irq output; irq=1 the cycle after count >= IRQ_LEVEL becomes true.
  - Drops the cycle after count falls below IRQ_LEVEL.
  - Reset value 0.
- Undefined: irq tied to constant 0; no irq register or comparator synthesized. All other behaviour is identical.

Decomposition:
- Shared package cpu_io_pkg:
  - WORD_W=32.
  - Default depth constant INPORT_DEPTH=8.
  - Function clog2 for pointer and count widths.
- One natural sub-module, fifo_ptr_ctrl: pointer/count/flag logic (push/pop qualification, wrap, full/empty, underflow).
- inport_fifo keeps the storage array, output mux and optional irq.

Test Plan:
- Reset → check empty=1, full=0, dev_ready=1, count=0, InPort_data_out=0, underflow=0. Then push 0x0000_00AA → next cycle InPort_data_out=0x0000_00AA, count=1, empty=0.
- Push 0x11, 0x22, 0x33; pulse InPort_read three times → outputs 0x11, 0x22, 0x33 in order, then empty=1 and InPort_data_out=0.
- Push 8 words 0x100..0x107 with DEPTH=8 → full=1, dev_ready=0. Hold dev_valid with 0x108 → not stored until one pop. After 8 more pops the sequence reads 0x101..0x108, confirming pointer wrap.
- count=3, then push and read in the same cycle → count stays 3; head advances to the second word.
- Read strobe while empty → underflow=1 and stays 1 through later pushes and pops. Assert reset low mid-stream with 5 words held → count=0, empty=1 and underflow=0 immediately, without waiting for a clock edge.
- With INPORT_FIFO_IRQ_EN and IRQ_LEVEL=4: push 4 words → irq=1 one cycle after count reaches 4; pop once → irq=0 one cycle later. Without the macro, irq stays 0 throughout the same stimulus.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared constants and helpers for the CPU I/O blocks.
package cpu_io_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned INPORT_DEPTH = 8;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag bookkeeping for the input-port FIFO.
module fifo_ptr_ctrl
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEPTH = INPORT_DEPTH,
  parameter int unsigned PTR_W = clog2(DEPTH),
  parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push_req,
  input  logic             i_pop_req,
  output logic             o_push,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_underflow
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // Flags come from the registered count only, so no input reaches dev_ready.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCnt);
  assign w_push  = i_push_req && !w_full;
  assign w_pop   = i_pop_req && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CntOne;
      2'b01:   w_count_nxt = r_count - CntOne;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      r_count <= w_count_nxt;
      if (i_pop_req && w_empty) r_underflow <= 1'b1;
    end
  end

  assign o_push      = w_push;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/inport_fifo.sv
// Show-ahead input-port FIFO between a valid/ready device and the CPU `in` strobe.
// Define INPORT_FIFO_IRQ_EN to build the registered occupancy interrupt.
module inport_fifo
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEPTH     = INPORT_DEPTH,
  parameter int unsigned IRQ_LEVEL = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           dev_data,
  input  logic                        dev_valid,
  output logic                        dev_ready,
  input  logic                        InPort_read,
  output logic [WORD_W-1:0]           InPort_data_out,
  output logic                        empty,
  output logic                        full,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        underflow,
  output logic                        irq
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam int unsigned CntW = clog2(DEPTH + 1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic              w_push;
  logic [PtrW-1:0]   w_wr_ptr;
  logic [PtrW-1:0]   w_rd_ptr;
  logic [CntW-1:0]   w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_underflow;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PtrW),
    .CNT_W (CntW)
  ) u_ptr_ctrl (
    .clock       (clock),
    .reset       (reset),
    .i_push_req  (dev_valid),
    .i_pop_req   (InPort_read),
    .o_push      (w_push),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_underflow (w_underflow)
  );

  // Storage is deliberately not reset; the pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[w_wr_ptr] <= dev_data;
  end

  assign InPort_data_out = w_empty ? '0 : r_mem[w_rd_ptr];
  assign dev_ready       = !w_full;
  assign empty           = w_empty;
  assign full            = w_full;
  assign count           = w_count;
  assign underflow       = w_underflow;

`ifdef INPORT_FIFO_IRQ_EN
  localparam logic [CntW-1:0] IrqCnt = CntW'(IRQ_LEVEL);

  logic r_irq;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_count >= IrqCnt);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_inport_fifo.sv
// Randomised and directed bench for inport_fifo against a queue-based model.
module tb_inport_fifo;
  import cpu_io_pkg::*;

  localparam int DEPTH     = 8;
  localparam int IRQ_LEVEL = 4;
`ifdef INPORT_FIFO_IRQ_EN
  localparam bit IrqOn = 1'b1;
`else
  localparam bit IrqOn = 1'b0;
`endif

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic [31:0] dev_data    = '0;
  logic        dev_valid   = 1'b0;
  logic        InPort_read = 1'b0;
  logic        dev_ready;
  logic [31:0] InPort_data_out;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        underflow;
  logic        irq;

  inport_fifo #(
    .DEPTH     (DEPTH),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dev_data        (dev_data),
    .dev_valid       (dev_valid),
    .dev_ready       (dev_ready),
    .InPort_read     (InPort_read),
    .InPort_data_out (InPort_data_out),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .underflow       (underflow),
    .irq             (irq)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of held words plus two sticky/registered bits.
  logic [31:0] q[$];
  bit          m_under = 1'b0;
  bit          m_irq   = 1'b0;

  always @(posedge clock or negedge reset) begin : model
    int n;
    bit pu;
    bit po;
    if (!reset) begin
      q.delete();
      m_under = 1'b0;
      m_irq   = 1'b0;
    end else begin
      n  = q.size();
      pu = dev_valid && (n < DEPTH);
      po = InPort_read && (n > 0);
      m_irq = IrqOn && (n >= IRQ_LEVEL);
      if (InPort_read && n == 0) m_under = 1'b1;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(dev_data);
    end
  end

  always @(negedge clock) begin : compare
    int n;
    n = q.size();
    chk("count",     32'(count),      32'(n));
    chk("empty",     32'(empty),      32'(n == 0));
    chk("full",      32'(full),       32'(n == DEPTH));
    chk("dev_ready", 32'(dev_ready),  32'(n != DEPTH));
    chk("data_out",  InPort_data_out, (n > 0) ? q[0] : 32'h0);
    chk("underflow", 32'(underflow),  32'(m_under));
    chk("irq",       32'(irq),        32'(m_irq));
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    dev_valid   = v;
    dev_data    = d;
    InPort_read = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(dev_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", InPort_data_out, 32'd0);
    chk("rst_under", 32'(underflow), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;

    cyc(1'b1, 32'hAA, 1'b0);
    chk("aa_data", InPort_data_out, 32'hAA);
    chk("aa_count", 32'(count), 32'd1);
    chk("aa_empty", 32'(empty), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("aa_popped", 32'(empty), 32'd1);

    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    cyc(1'b1, 32'h33, 1'b0);
    chk("ord_11", InPort_data_out, 32'h11);
    chk("ord_cnt", 32'(count), 32'd3);
    cyc(1'b0, 32'h0, 1'b1);
    chk("ord_22", InPort_data_out, 32'h22);
    cyc(1'b0, 32'h0, 1'b1);
    chk("ord_33", InPort_data_out, 32'h33);
    cyc(1'b0, 32'h0, 1'b1);
    chk("ord_empty", 32'(empty), 32'd1);
    chk("ord_zero", InPort_data_out, 32'h0);

    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
    chk("wrap_full", 32'(full), 32'd1);
    chk("wrap_ready", 32'(dev_ready), 32'd0);
    chk("wrap_cnt8", 32'(count), 32'd8);
    cyc(1'b1, 32'h108, 1'b0);
    chk("wrap_held", 32'(count), 32'd8);
    chk("wrap_head", InPort_data_out, 32'h100);
    cyc(1'b1, 32'h108, 1'b1);
    chk("wrap_popfull_cnt", 32'(count), 32'd7);
    chk("wrap_ready_rise", 32'(dev_ready), 32'd1);
    cyc(1'b1, 32'h108, 1'b0);
    chk("wrap_refill", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_seq", InPort_data_out, 32'h101 + 32'(i));
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk("wrap_drained", 32'(empty), 32'd1);

    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0);
    chk("irq_cnt4", 32'(count), 32'd4);
    chk("irq_not_yet", 32'(irq), 32'd0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("irq_rise", 32'(irq), 32'(IrqOn));
    cyc(1'b0, 32'h0, 1'b1);
    chk("irq_cnt3", 32'(count), 32'd3);
    chk("irq_still", 32'(irq), 32'(IrqOn));
    cyc(1'b0, 32'h0, 1'b0);
    chk("irq_fall", 32'(irq), 32'd0);

    cyc(1'b1, 32'h300, 1'b1);
    chk("pp_cnt", 32'(count), 32'd3);
    chk("pp_head", InPort_data_out, 32'h202);
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
    chk("pp_drained", 32'(empty), 32'd1);

    cyc(1'b0, 32'h0, 1'b1);
    chk("uf_set", 32'(underflow), 32'd1);
    chk("uf_cnt", 32'(count), 32'd0);
    cyc(1'b1, 32'h400, 1'b1);
    chk("uf_push_cnt", 32'(count), 32'd1);
    chk("uf_push_data", InPort_data_out, 32'h400);
    for (int i = 1; i < 5; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("uf_sticky", 32'(underflow), 32'd1);
    cyc(1'b1, 32'h405, 1'b0);
    chk("uf_cnt5", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_under", 32'(underflow), 32'd0);
    chk("ar_data", InPort_data_out, 32'd0);
    chk("ar_ready", 32'(dev_ready), 32'd1);
    cyc(1'b1, 32'h500, 1'b1);
    chk("ar_no_push", 32'(count), 32'd0);
    reset = 1'b1;
    cyc(1'b0, 32'h0, 1'b0);
    chk("ar_after", 32'(count), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int ph;
      int pv;
      int pr;
      ph = (i / 100) % 3;
      pv = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
      pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        #1;
        cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        reset = 1'b1;
      end else begin
        cyc(1'($urandom_range(0, 99) < pv), $urandom, 1'($urandom_range(0, 99) < pr));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
